// File: rtl/keypad_clock_div.sv
// Keypad support block: free-running scan clock divider, restartable debounce
// interval timer, and a combinational priority encoder for the 12-key matrix.
module keypad_clock_div #(
  parameter int unsigned CLK_FREQ_HZ     = 100000000,
  parameter int unsigned OUT_FREQ_HZ     = 100,
  parameter int unsigned DEBOUNCE_CYCLES = 2000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        db_reset,
  input  logic [11:0] keys,
  output logic        clk_out,
  output logic        counter_done,
  output logic [3:0]  enc_out
);

  localparam int unsigned HALF  = CLK_FREQ_HZ / (2 * OUT_FREQ_HZ);
  localparam int unsigned DIV_W = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int unsigned DB_W  = $clog2(DEBOUNCE_CYCLES);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(HALF - 1);
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] COUNT = 1'b1;

  logic [DIV_W-1:0] div_cnt;
  logic [DB_W-1:0]  db_cnt;
  logic [0:0]       db_state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
      clk_out <= 1'b0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
      clk_out <= ~clk_out;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // db_reset restarts from any state; the interval only begins once it drops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      db_state     <= IDLE;
      db_cnt       <= '0;
      counter_done <= 1'b0;
    end else if (db_reset) begin
      db_state     <= COUNT;
      db_cnt       <= '0;
      counter_done <= 1'b0;
    end else begin
      case (db_state)
        COUNT: begin
          if (db_cnt == DB_LAST) begin
            db_state     <= IDLE;
            db_cnt       <= '0;
            counter_done <= 1'b1;
          end else begin
            db_cnt       <= db_cnt + 1'b1;
            counter_done <= 1'b0;
          end
        end
        default: begin
          db_cnt       <= '0;
          counter_done <= 1'b0;
        end
      endcase
    end
  end

  // Ascending scan so the highest set key wins; 4'hF means no key pressed.
  always_comb begin
    enc_out = 4'hF;
    for (int unsigned i = 0; i < 12; i++) begin
      if (keys[i]) enc_out = 4'(i);
    end
  end

endmodule

// File: tb/tb_keypad_clock_div.sv
// Self-checking bench for keypad_clock_div with small parameters
// (HALF = 5, DEBOUNCE_CYCLES = 8).
module tb_keypad_clock_div;

  localparam int unsigned CLK_HZ = 1000;
  localparam int unsigned OUT_HZ = 100;
  localparam int unsigned DB     = 8;
  localparam int unsigned HALF   = CLK_HZ / (2 * OUT_HZ);

  logic        clk = 1'b0;
  logic        reset;
  logic        db_reset;
  logic [11:0] keys;
  logic        clk_out;
  logic        counter_done;
  logic [3:0]  enc_out;

  keypad_clock_div #(
    .CLK_FREQ_HZ    (CLK_HZ),
    .OUT_FREQ_HZ    (OUT_HZ),
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .db_reset    (db_reset),
    .keys        (keys),
    .clk_out     (clk_out),
    .counter_done(counter_done),
    .enc_out     (enc_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] k;
    int          exp;
  } enc_vec_t;

  enc_vec_t tbl[6];

  int passed = 0;
  int total  = 0;

  // Reference model: edges since reset release, and edges since the last
  // cycle in which db_reset was sampled high.
  int n_edges;
  bit armed;
  int elapsed;
  bit m_done;

  function automatic int enc_model(input logic [11:0] k);
    if (k == 12'd0) return 15;
    return $clog2(int'(k) + 1) - 1;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    n_edges = 0;
    armed   = 0;
    elapsed = 0;
    m_done  = 0;
  endtask

  task automatic step();
    @(posedge clk);
    if (reset) begin
      model_reset();
    end else begin
      n_edges++;
      m_done = 0;
      if (db_reset) begin
        armed   = 1;
        elapsed = 0;
      end else if (armed) begin
        elapsed++;
        if (elapsed == DB) begin
          m_done = 1;
          armed  = 0;
        end
      end
    end
    #1;
    check("clk_out", clk_out, (n_edges / HALF) % 2);
    check("counter_done", counter_done, m_done);
    check("enc_out", enc_out, enc_model(keys));
  endtask

  task automatic async_reset();
    #3;
    reset = 1'b1;
    #1;
    model_reset();
    check("async_clk_out", clk_out, 0);
    check("async_counter_done", counter_done, 0);
    check("async_enc_out", enc_out, enc_model(keys));
    #1;
    reset = 1'b0;
  endtask

  task automatic pulse_db();
    db_reset = 1'b1;
    step();
    db_reset = 1'b0;
  endtask

  task automatic watch(input int cycles, output int first, output int pulses);
    first  = -1;
    pulses = 0;
    for (int i = 1; i <= cycles; i++) begin
      step();
      if (counter_done) begin
        pulses++;
        if (first < 0) first = i;
      end
    end
  endtask

  int first, pulses;

  initial begin
    tbl[0] = '{12'h000, 15};
    tbl[1] = '{12'h001, 0};
    tbl[2] = '{12'h200, 9};
    tbl[3] = '{12'h400, 10};
    tbl[4] = '{12'h800, 11};
    tbl[5] = '{12'h0A2, 7};

    reset    = 1'b1;
    db_reset = 1'b0;
    keys     = '0;
    model_reset();
    #12;
    check("reset_clk_out", clk_out, 0);
    check("reset_counter_done", counter_done, 0);
    check("reset_enc_out", enc_out, 15);
    reset = 1'b0;

    // Divider waveform over 40 cycles
    for (int i = 0; i < 40; i++) step();

    // Single db_reset pulse
    pulse_db();
    watch(20, first, pulses);
    check("single_pulse_latency", first, DB);
    check("single_pulse_count", pulses, 1);

    // Re-trigger at count 5
    pulse_db();
    for (int i = 0; i < 5; i++) step();
    pulse_db();
    watch(15, first, pulses);
    check("retrig_latency", first, DB);
    check("retrig_count", pulses, 1);

    // Async reset mid-interval aborts it
    pulse_db();
    for (int i = 0; i < 4; i++) step();
    async_reset();
    watch(15, first, pulses);
    check("abort_count", pulses, 0);

    // Reset held across edges beats db_reset
    reset    = 1'b1;
    db_reset = 1'b1;
    step();
    step();
    reset    = 1'b0;
    db_reset = 1'b0;
    watch(12, first, pulses);
    check("reset_over_db_count", pulses, 0);

    // db_reset held for 5 cycles
    db_reset = 1'b1;
    watch(5, first, pulses);
    check("held_db_count", pulses, 0);
    db_reset = 1'b0;
    watch(12, first, pulses);
    check("held_release_latency", first, DB);
    check("held_release_count", pulses, 1);

    // Encoder vector table
    for (int i = 0; i < 6; i++) begin
      keys = tbl[i].k;
      #1;
      check("enc_table", enc_out, tbl[i].exp);
    end

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      keys     = ($urandom_range(0, 5) == 0) ? 12'h000 : 12'($urandom);
      db_reset = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 79) == 0) async_reset();
      step();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
